// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with valid/ready on both sides, optional skid entry,
// global stall (freeze) and flush (kill held entries).
module pipe_stage_reg #(
  parameter int unsigned WIDTH   = 64,
  parameter bit          SKID_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occ
);

  logic             main_v_q, main_v_d;
  logic             skid_v_q, skid_v_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             active;
  logic             in_fire;
  logic             out_fire;

  assign active = !stall && !flush;

  always_comb begin
    out_valid = main_v_q && active;
    // With the skid entry, in_ready comes straight from a flop (plus stall/flush masking).
    if (SKID_EN) begin
      in_ready = !skid_v_q && active;
    end else begin
      in_ready = active && (!main_v_q || out_ready);
    end
  end

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    main_d   = main_q;
    skid_d   = skid_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!stall) begin
      if (SKID_EN) begin
        if (!main_v_q || out_fire) begin
          // in_fire cannot coincide with a held skid entry, so the skid simply drains.
          if (skid_v_q) begin
            main_d   = skid_q;
            main_v_d = 1'b1;
            skid_v_d = 1'b0;
          end else if (in_fire) begin
            main_d   = in_data;
            main_v_d = 1'b1;
          end else begin
            main_v_d = 1'b0;
          end
        end else if (in_fire) begin
          skid_d   = in_data;
          skid_v_d = 1'b1;
        end
      end else begin
        if (in_fire) begin
          main_d   = in_data;
          main_v_d = 1'b1;
        end else if (out_fire) begin
          main_v_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
    end
  end

  assign out_data = main_q;
  assign occ      = {1'b0, main_v_q} + {1'b0, skid_v_q};

endmodule
